// File: rtl/sobel_scan_source_if.sv
// Pixel stream bundle: upstream valid/ready side plus the positioned filter side.
// The master modport belongs to the scan source; the slave modport to whoever drives/observes it.
interface sobel_scan_source_if;
    logic        src_valid;
    logic [23:0] src_data;
    logic        src_ready;
    logic [11:0] posx;
    logic [11:0] posy;
    logic        ready;
    logic        rden;
    logic [7:0]  in_r;
    logic [7:0]  in_g;
    logic [7:0]  in_b;

    modport master (
        input  src_valid, src_data, rden,
        output src_ready, posx, posy, ready, in_r, in_g, in_b
    );

    modport slave (
        output src_valid, src_data, rden,
        input  src_ready, posx, posy, ready, in_r, in_g, in_b
    );
endinterface

// File: rtl/sobel_scan_source.sv
// Raster-scan pixel source for a 3x3 filter: one-entry pixel register, line gaps, latency flush.
// Define SOBEL_SCAN_TEST_PATTERN_EN to replace upstream data with a position-derived pattern.
//
// state     | meaning
// ST_IDLE   | waiting for start
// ST_SCAN   | offering pixels of the current line
// ST_HBLANK | idle gap after a line, held pixel stays in the register
// ST_FLUSH  | drain filter latency; frame_done on the last cycle
module sobel_scan_source #(
    parameter int H_SIZE = 1920,
    parameter int V_SIZE = 1080,
    parameter int HBLANK = 16,
    parameter int FLUSH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    sobel_scan_source_if.master        px,
    output logic                       busy,
    output logic                       frame_done,
    output logic [15:0]                frame_cnt
);
    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_HBLANK, ST_FLUSH} state_t;

    localparam logic [11:0] X_LAST  = 12'(H_SIZE - 1);
    localparam logic [11:0] Y_LAST  = 12'(V_SIZE - 1);
    localparam logic [15:0] HB_INIT = 16'(HBLANK);
    localparam logic [15:0] FL_INIT = 16'(FLUSH);

    state_t      state_q, state_d;
    logic        pr_valid_q, pr_valid_d;
    logic [23:0] pr_data_q, pr_data_d;
    logic [11:0] posx_q, posx_d;
    logic [11:0] posy_q, posy_d;
    logic [15:0] cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        frame_done_q, frame_done_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;

    logic        ready, beat, x_last, y_last, frame_end, pull, load, src_ready, fin;
    logic [11:0] nx, ny;
    logic [23:0] load_data;
`ifdef SOBEL_SCAN_TEST_PATTERN_EN
    logic [11:0] lx, ly;
    logic        unused_src;
`endif

    always_comb begin
        ready     = pr_valid_q && (state_q == ST_SCAN);
        beat      = ready && px.rden;
        x_last    = (posx_q == X_LAST);
        y_last    = (posy_q == Y_LAST);
        frame_end = beat && x_last && y_last;
        nx        = x_last ? 12'd0 : posx_q + 12'd1;
        ny        = x_last ? posy_q + 12'd1 : posy_q;
        // Never pull past the final pixel: the next frame's data must stay upstream.
        pull      = (state_q == ST_SCAN) && (!pr_valid_q || beat) && !frame_end;
`ifdef SOBEL_SCAN_TEST_PATTERN_EN
        unused_src = ^{px.src_valid, px.src_data};
        lx         = beat ? nx : posx_q;
        ly         = beat ? ny : posy_q;
        src_ready  = 1'b0;
        load       = pull;
        load_data  = {lx[7:0], ly[7:0], lx[7:0] ^ ly[7:0]};
`else
        src_ready  = pull;
        load       = pull && px.src_valid;
        load_data  = px.src_data;
`endif

        state_d      = state_q;
        pr_valid_d   = pr_valid_q;
        pr_data_d    = pr_data_q;
        posx_d       = posx_q;
        posy_d       = posy_q;
        cnt_d        = cnt_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        fin          = 1'b0;

        if (load) begin
            pr_valid_d = 1'b1;
            pr_data_d  = load_data;
        end else if (beat) begin
            pr_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                // frame_done_q guards the FLUSH==0 case where the pulse lands in IDLE
                if (start && !frame_done_q) begin
                    state_d = ST_SCAN;
                    posx_d  = 12'd0;
                    posy_d  = 12'd0;
                    busy_d  = 1'b1;
                end
            end
            ST_SCAN: begin
                if (beat) begin
                    posx_d = nx;
                    if (x_last) begin
                        if (y_last) begin
                            if (FLUSH == 0) begin
                                state_d = ST_IDLE;
                            end else begin
                                state_d = ST_FLUSH;
                                cnt_d   = FL_INIT;
                            end
                            fin = (FLUSH <= 1);
                        end else begin
                            posy_d = ny;
                            if (HBLANK != 0) begin
                                state_d = ST_HBLANK;
                                cnt_d   = HB_INIT;
                            end
                        end
                    end
                end
            end
            ST_HBLANK: begin
                if (cnt_q <= 16'd1) state_d = ST_SCAN;
                else                cnt_d   = cnt_q - 16'd1;
            end
            ST_FLUSH: begin
                if (cnt_q <= 16'd1) state_d = ST_IDLE;
                else                cnt_d   = cnt_q - 16'd1;
                fin = (cnt_q == 16'd2);
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered, so the done pulse is set one edge early to land on the last flush cycle.
        if (fin) begin
            frame_done_d = 1'b1;
            busy_d       = 1'b0;
            frame_cnt_d  = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            pr_valid_q   <= 1'b0;
            pr_data_q    <= 24'd0;
            posx_q       <= 12'd0;
            posy_q       <= 12'd0;
            cnt_q        <= 16'd0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= 16'd0;
        end else begin
            state_q      <= state_d;
            pr_valid_q   <= pr_valid_d;
            pr_data_q    <= pr_data_d;
            posx_q       <= posx_d;
            posy_q       <= posy_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign px.src_ready = src_ready;
    assign px.ready     = ready;
    assign px.posx      = posx_q;
    assign px.posy      = posy_q;
    assign px.in_r      = pr_data_q[23:16];
    assign px.in_g      = pr_data_q[15:8];
    assign px.in_b      = pr_data_q[7:0];
    assign busy         = busy_q;
    assign frame_done   = frame_done_q;
    assign frame_cnt    = frame_cnt_q;
endmodule
